// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the UART command system controller: command bytes,
// FSM state encoding and the fixed ALU operand addresses.
package sys_ctrl_pkg;

    // Command bytes that open a frame
    localparam logic [7:0] CMD_WRITE   = 8'hAA;
    localparam logic [7:0] CMD_READ    = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
    localparam logic [7:0] CMD_BURST   = 8'hEE;

    // RegFile locations that feed the ALU operands
    localparam int ALU_OP1_ADDR = 0;
    localparam int ALU_OP2_ADDR = 1;

    typedef enum logic [3:0] {
        S_CFG_WR,
        S_IDLE,
        S_WAIT_ADDR,
        S_WAIT_DATA,
        S_WRITE,
        S_READ,
        S_PUSH,
        S_WAIT_OP1,
        S_WR_OP1,
        S_WAIT_OP2,
        S_WR_OP2,
        S_WAIT_FUN,
        S_ALU_CALC,
        S_PUSH_LO,
        S_PUSH_HI,
        S_WAIT_CNT
    } state_e;

    // Which address-carrying command is in flight (steers WAIT_ADDR)
    typedef enum logic [1:0] {
        OP_WRITE,
        OP_READ,
        OP_BURST
    } op_e;

endpackage

// File: rtl/sys_ctrl_burst_frame_timer.sv
// Inter-byte idle counter: cleared on demand, counts while enabled and
// saturates at the timeout value, where it flags expiry.
module frame_timer #(
    parameter int TO_WIDTH       = 10,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TO_WIDTH-1:0] cnt_q;

    assign expired_o = (cnt_q == TO_WIDTH'(TIMEOUT_CYCLES));

    // Idle-cycle counter, held at the expiry value until cleared
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + TO_WIDTH'(1);
        end
    end

endmodule

// File: rtl/sys_ctrl_burst.sv
// UART command system controller: decodes framed command bytes and drives
// RegFile writes/reads, the ALU and pushes into the TX FIFO, with burst
// reads, an inter-byte frame timeout and FIFO-full-safe pushes.
module sys_ctrl_burst
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int CFG_ADDR       = 2,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int TO_WIDTH       = 10
) (
    input  logic                      i_CLK,
    input  logic                      i_RST,
    input  logic [DATA_WIDTH-1:0]     i_RX_P_DATA,
    input  logic                      i_RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]     i_Cfg_Word,
    input  logic [DATA_WIDTH-1:0]     i_RdData,
    input  logic                      i_RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0]   i_ALU_OUT,
    input  logic                      i_OUT_Valid,
    input  logic                      i_FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]     o_Address,
    output logic [DATA_WIDTH-1:0]     o_WrData,
    output logic                      o_WrEn,
    output logic                      o_RdEn,
    output logic [ALU_FUN_WIDTH-1:0]  o_ALU_FUN,
    output logic                      o_ALU_EN,
    output logic                      o_CLK_EN,
    output logic [DATA_WIDTH-1:0]     o_FIFO_DATA,
    output logic                      o_WR_INC,
    output logic                      o_clk_div_en,
    output logic                      o_Busy,
    output logic                      o_Frame_Err
);

    state_e                     state_q, state_d;
    op_e                        op_q, op_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic [DATA_WIDTH-1:0]      count_q, count_d;
    logic [ALU_FUN_WIDTH-1:0]   fun_q, fun_d;
    logic [2*DATA_WIDTH-1:0]    alu_q, alu_d;

    logic is_wait;
    logic to_expired;
    logic cmd_known;

    assign is_wait = state_q inside {S_WAIT_ADDR, S_WAIT_DATA, S_WAIT_OP1,
                                     S_WAIT_OP2, S_WAIT_FUN, S_WAIT_CNT};

    assign cmd_known = i_RX_P_DATA inside {DATA_WIDTH'(CMD_WRITE), DATA_WIDTH'(CMD_READ),
                                           DATA_WIDTH'(CMD_ALU_OP), DATA_WIDTH'(CMD_ALU_NOP),
                                           DATA_WIDTH'(CMD_BURST)};

    assign o_clk_div_en = 1'b1;

    // Timer restarts on every accepted byte and whenever no frame is pending
    frame_timer #(
        .TO_WIDTH       (TO_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk       (i_CLK),
        .rst_n     (i_RST),
        .clr_i     (!is_wait || i_RX_D_VLD),
        .en_i      (is_wait),
        .expired_o (to_expired)
    );

    // State and frame registers; reset aborts any frame and restarts at CFG_WR
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q <= S_CFG_WR;
            op_q    <= OP_WRITE;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            fun_q   <= '0;
            alu_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            fun_q   <= fun_d;
            alu_q   <= alu_d;
        end
    end

    // Next-state and frame-capture logic
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        fun_d   = fun_q;
        alu_d   = alu_q;
        case (state_q)
            S_CFG_WR: state_d = S_IDLE;
            S_IDLE: begin
                if (i_RX_D_VLD) begin
                    if (i_RX_P_DATA == DATA_WIDTH'(CMD_WRITE)) begin
                        op_d    = OP_WRITE;
                        state_d = S_WAIT_ADDR;
                    end else if (i_RX_P_DATA == DATA_WIDTH'(CMD_READ)) begin
                        op_d    = OP_READ;
                        count_d = DATA_WIDTH'(1);
                        state_d = S_WAIT_ADDR;
                    end else if (i_RX_P_DATA == DATA_WIDTH'(CMD_BURST)) begin
                        op_d    = OP_BURST;
                        state_d = S_WAIT_ADDR;
                    end else if (i_RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP)) begin
                        state_d = S_WAIT_OP1;
                    end else if (i_RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) begin
                        state_d = S_WAIT_FUN;
                    end
                end
            end
            S_WAIT_ADDR: begin
                if (i_RX_D_VLD) begin
                    addr_d = i_RX_P_DATA[ADDR_WIDTH-1:0];
                    case (op_q)
                        OP_WRITE: state_d = S_WAIT_DATA;
                        OP_READ:  state_d = S_READ;
                        default:  state_d = S_WAIT_CNT;
                    endcase
                end else if (to_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_DATA, S_WAIT_OP1, S_WAIT_OP2: begin
                if (i_RX_D_VLD) begin
                    data_d  = i_RX_P_DATA;
                    state_d = (state_q == S_WAIT_DATA) ? S_WRITE :
                              (state_q == S_WAIT_OP1)  ? S_WR_OP1 : S_WR_OP2;
                end else if (to_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_CNT: begin
                if (i_RX_D_VLD) begin
                    // A zero count still performs one read
                    count_d = (i_RX_P_DATA == '0) ? DATA_WIDTH'(1) : i_RX_P_DATA;
                    state_d = S_READ;
                end else if (to_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_FUN: begin
                if (i_RX_D_VLD) begin
                    fun_d   = i_RX_P_DATA[ALU_FUN_WIDTH-1:0];
                    state_d = S_ALU_CALC;
                end else if (to_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE:  state_d = S_IDLE;
            S_WR_OP1: state_d = S_WAIT_OP2;
            S_WR_OP2: state_d = S_WAIT_FUN;
            S_READ: begin
                if (i_RdData_Valid) begin
                    data_d  = i_RdData;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (!i_FIFO_FULL) begin
                    if (count_q > DATA_WIDTH'(1)) begin
                        count_d = count_q - DATA_WIDTH'(1);
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = S_READ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ALU_CALC: begin
                if (i_OUT_Valid) begin
                    alu_d   = i_ALU_OUT;
                    state_d = S_PUSH_LO;
                end
            end
            S_PUSH_LO: if (!i_FIFO_FULL) state_d = S_PUSH_HI;
            S_PUSH_HI: if (!i_FIFO_FULL) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output decode; CFG_WR drives nothing while reset is still asserted
    always_comb begin
        o_Address   = '0;
        o_WrData    = '0;
        o_WrEn      = 1'b0;
        o_RdEn      = 1'b0;
        o_ALU_FUN   = '0;
        o_ALU_EN    = 1'b0;
        o_CLK_EN    = 1'b0;
        o_FIFO_DATA = '0;
        o_WR_INC    = 1'b0;
        o_Busy      = i_RST && (state_q != S_IDLE);
        o_Frame_Err = is_wait && to_expired && !i_RX_D_VLD;
        case (state_q)
            S_CFG_WR: begin
                if (i_RST) begin
                    o_WrEn    = 1'b1;
                    o_Address = ADDR_WIDTH'(CFG_ADDR);
                    o_WrData  = i_Cfg_Word;
                end
            end
            S_IDLE: o_Frame_Err = i_RX_D_VLD && !cmd_known;
            S_WRITE: begin
                o_WrEn    = 1'b1;
                o_Address = addr_q;
                o_WrData  = data_q;
            end
            S_WR_OP1: begin
                o_WrEn    = 1'b1;
                o_Address = ADDR_WIDTH'(ALU_OP1_ADDR);
                o_WrData  = data_q;
            end
            S_WR_OP2: begin
                o_WrEn    = 1'b1;
                o_Address = ADDR_WIDTH'(ALU_OP2_ADDR);
                o_WrData  = data_q;
            end
            S_READ: begin
                o_RdEn    = 1'b1;
                o_Address = addr_q;
            end
            S_ALU_CALC: begin
                o_ALU_EN  = 1'b1;
                o_CLK_EN  = 1'b1;
                o_ALU_FUN = fun_q;
            end
            S_PUSH: begin
                o_FIFO_DATA = data_q;
                o_WR_INC    = !i_FIFO_FULL;
            end
            S_PUSH_LO: begin
                o_FIFO_DATA = alu_q[DATA_WIDTH-1:0];
                o_WR_INC    = !i_FIFO_FULL;
            end
            S_PUSH_HI: begin
                o_FIFO_DATA = alu_q[2*DATA_WIDTH-1:DATA_WIDTH];
                o_WR_INC    = !i_FIFO_FULL;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Directed bench for sys_ctrl_burst: inputs change 1ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_sys_ctrl_burst;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;
    localparam int TO = 20;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   rx_data;
    logic            rx_vld;
    logic [DW-1:0]   cfg_word;
    logic [DW-1:0]   rd_data;
    logic            rd_vld;
    logic [2*DW-1:0] alu_out;
    logic            alu_vld;
    logic            fifo_full;
    logic [AW-1:0]   address;
    logic [DW-1:0]   wr_data;
    logic            wr_en;
    logic            rd_en;
    logic [FW-1:0]   alu_fun;
    logic            alu_en;
    logic            clk_en;
    logic [DW-1:0]   fifo_data;
    logic            wr_inc;
    logic            clk_div_en;
    logic            busy;
    logic            frame_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sys_ctrl_burst #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .ALU_FUN_WIDTH  (FW),
        .CFG_ADDR       (2),
        .TIMEOUT_CYCLES (TO),
        .TO_WIDTH       (5)
    ) dut (
        .i_CLK          (clk),
        .i_RST          (rst_n),
        .i_RX_P_DATA    (rx_data),
        .i_RX_D_VLD     (rx_vld),
        .i_Cfg_Word     (cfg_word),
        .i_RdData       (rd_data),
        .i_RdData_Valid (rd_vld),
        .i_ALU_OUT      (alu_out),
        .i_OUT_Valid    (alu_vld),
        .i_FIFO_FULL    (fifo_full),
        .o_Address      (address),
        .o_WrData       (wr_data),
        .o_WrEn         (wr_en),
        .o_RdEn         (rd_en),
        .o_ALU_FUN      (alu_fun),
        .o_ALU_EN       (alu_en),
        .o_CLK_EN       (clk_en),
        .o_FIFO_DATA    (fifo_data),
        .o_WR_INC       (wr_inc),
        .o_clk_div_en   (clk_div_en),
        .o_Busy         (busy),
        .o_Frame_Err    (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_vld  = 1'b1;
        step();
        rx_vld  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        rx_data   = '0;
        rx_vld    = 1'b0;
        cfg_word  = 8'h81;
        rd_data   = '0;
        rd_vld    = 1'b0;
        alu_out   = '0;
        alu_vld   = 1'b0;
        fifo_full = 1'b0;

        // Reset: everything quiet except the divider enable
        sample();
        check("rst_wren", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_wrinc", wr_inc, 0);
        check("rst_err", frame_err, 0);
        check("rst_diven", clk_div_en, 1);

        // Release: one config write at address 2
        step();
        rst_n = 1'b1;
        sample();
        check("cfg_wren", wr_en, 1);
        check("cfg_addr", address, 2);
        check("cfg_data", wr_data, 8'h81);
        check("cfg_busy", busy, 1);
        step();
        sample();
        check("cfg_busy_fall", busy, 0);
        check("cfg_wren_fall", wr_en, 0);

        // AA,05,3C: single write of 3C at 5
        send(8'hAA);
        send(8'h05);
        send(8'h3C);
        sample();
        check("wr_wren", wr_en, 1);
        check("wr_addr", address, 5);
        check("wr_data", wr_data, 8'h3C);
        check("wr_noinc", wr_inc, 0);
        step();
        sample();
        check("wr_done_wren", wr_en, 0);
        check("wr_done_busy", busy, 0);

        // CC,0A,03,00 with ALU result 000D
        send(8'hCC);
        send(8'h0A);
        sample();
        check("op1_wren", wr_en, 1);
        check("op1_addr", address, 0);
        check("op1_data", wr_data, 8'h0A);
        step();
        send(8'h03);
        sample();
        check("op2_wren", wr_en, 1);
        check("op2_addr", address, 1);
        check("op2_data", wr_data, 8'h03);
        step();
        send(8'h00);
        sample();
        check("alu_en_c0", alu_en, 1);
        check("alu_clken_c0", clk_en, 1);
        check("alu_fun", alu_fun, 0);
        step();
        sample();
        check("alu_en_hold", alu_en, 1);
        alu_out = 16'h000D;
        alu_vld = 1'b1;
        step();
        alu_vld = 1'b0;
        alu_out = 16'hFFFF;
        sample();
        check("alu_lo_inc", wr_inc, 1);
        check("alu_lo_data", fifo_data, 8'h0D);
        check("alu_lo_en_off", alu_en, 0);
        step();
        sample();
        check("alu_hi_inc", wr_inc, 1);
        check("alu_hi_data", fifo_data, 8'h00);
        step();
        sample();
        check("alu_done_busy", busy, 0);

        // DD,37 with ALU result BEEF: function uses low nibble only
        send(8'hDD);
        send(8'h37);
        sample();
        check("dd_fun", alu_fun, 4'h7);
        check("dd_en", alu_en, 1);
        alu_out = 16'hBEEF;
        alu_vld = 1'b1;
        step();
        alu_vld = 1'b0;
        sample();
        check("dd_lo", fifo_data, 8'hEF);
        step();
        sample();
        check("dd_hi", fifo_data, 8'hBE);
        check("dd_hi_inc", wr_inc, 1);
        step();

        // EE,0E,03: burst reads at E, F, 0
        send(8'hEE);
        send(8'h0E);
        send(8'h03);
        sample();
        check("b0_rden", rd_en, 1);
        check("b0_addr", address, 4'hE);
        step();
        sample();
        check("b0_rden_hold", rd_en, 1);
        check("b0_noinc", wr_inc, 0);
        rd_data = 8'h11;
        rd_vld  = 1'b1;
        step();
        rd_vld  = 1'b0;
        sample();
        check("b0_push", wr_inc, 1);
        check("b0_data", fifo_data, 8'h11);
        step();
        sample();
        check("b1_addr", address, 4'hF);
        check("b1_rden", rd_en, 1);
        rd_data = 8'h22;
        rd_vld  = 1'b1;
        step();
        rd_vld  = 1'b0;
        sample();
        check("b1_data", fifo_data, 8'h22);
        step();
        sample();
        check("b2_addr_wrap", address, 4'h0);
        rd_data = 8'h33;
        rd_vld  = 1'b1;
        step();
        rd_vld  = 1'b0;
        sample();
        check("b2_data", fifo_data, 8'h33);
        check("b2_push", wr_inc, 1);
        step();
        sample();
        check("burst_done_busy", busy, 0);

        // EE,03,00: zero count behaves as one read
        send(8'hEE);
        send(8'h03);
        send(8'h00);
        sample();
        check("n0_addr", address, 3);
        rd_data = 8'h44;
        rd_vld  = 1'b1;
        step();
        rd_vld  = 1'b0;
        sample();
        check("n0_data", fifo_data, 8'h44);
        step();
        sample();
        check("n0_done_busy", busy, 0);

        // BB,04 with FIFO full for 10 cycles
        send(8'hBB);
        send(8'h04);
        sample();
        check("rd_addr", address, 4);
        check("rd_rden", rd_en, 1);
        fifo_full = 1'b1;
        rd_data   = 8'h5A;
        rd_vld    = 1'b1;
        step();
        rd_vld    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample();
            check("full_noinc", wr_inc, 0);
            check("full_data", fifo_data, 8'h5A);
            step();
        end
        fifo_full = 1'b0;
        sample();
        check("full_release_inc", wr_inc, 1);
        check("full_release_data", fifo_data, 8'h5A);
        step();
        sample();
        check("full_done_inc", wr_inc, 0);
        check("full_done_busy", busy, 0);

        // AA,05 then silence: error exactly at the timeout cycle, no write
        send(8'hAA);
        send(8'h05);
        for (int i = 0; i <= TO; i++) begin
            sample();
            check($sformatf("to_err_c%0d", i), frame_err, (i == TO) ? 1 : 0);
            check("to_nowren", wr_en, 0);
            step();
        end
        sample();
        check("to_idle", busy, 0);
        check("to_err_off", frame_err, 0);
        check("to_nowren_after", wr_en, 0);

        // Unknown command in IDLE
        rx_data = 8'h7F;
        rx_vld  = 1'b1;
        sample();
        check("bad_err", frame_err, 1);
        check("bad_busy", busy, 0);
        step();
        rx_vld = 1'b0;
        sample();
        check("bad_err_off", frame_err, 0);
        check("bad_stay_idle", busy, 0);

        // Byte during a non-wait state is ignored (READ holds)
        send(8'hBB);
        send(8'h09);
        rx_data = 8'hAA;
        rx_vld  = 1'b1;
        step();
        rx_vld  = 1'b0;
        sample();
        check("ign_rden", rd_en, 1);
        check("ign_addr", address, 9);

        // Async reset mid-frame returns to CFG_WR
        #1;
        rst_n = 1'b0;
        sample();
        check("midrst_rden", rd_en, 0);
        check("midrst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        sample();
        check("midrst_cfg_wren", wr_en, 1);
        check("midrst_cfg_addr", address, 2);
        step();
        sample();
        check("midrst_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
